// File: rtl/mm_radix_pipe_param.sv
// mm_radix_pipe_param: digit-serial Montgomery multiply-accumulate, D_o = (A*B+D)*2^-WIDTH mod M
module mm_radix_pipe_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             init,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  input  logic [DIGIT-1:0] M0,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] D_o,
  output logic             busy,
  output logic             done
);
  localparam int N = WIDTH / DIGIT;
  localparam int SW = WIDTH + DIGIT + 2;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d, t, u;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, d_o_q, d_o_d;
  logic [DIGIT-1:0] m0_q, m0_d, q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  assign D_o = d_o_q;
  assign busy = busy_q;
  assign done = done_q;
  // one radix-2^DIGIT Montgomery step; q makes the low DIGIT bits of u zero
  always_comb begin
    t = s_q + SW'(a_q[DIGIT-1:0]) * SW'(b_q);
    q = t[DIGIT-1:0] * m0_q;
    u = t + SW'(q) * SW'(m_q);
  end
  // next-state logic for the IDLE -> RUN -> FIN sequence
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    m0_d = m0_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    d_o_d = d_o_q;
    case (state_q)
      IDLE: if (init) begin
        state_d = RUN;
        a_d = A;
        b_d = B;
        m_d = M;
        m0_d = M0;
        s_d = SW'(D);
        cnt_d = '0;
        busy_d = 1'b1;
      end
      RUN: begin
        s_d = u >> DIGIT;
        a_d = a_q >> DIGIT;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1)) ? FIN : RUN;
      end
      FIN: begin
        d_o_d = WIDTH'((s_q >= SW'(m_q)) ? s_q - SW'(m_q) : s_q);
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // all registers; ce low freezes every one of them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      m0_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_o_q <= '0;
    end else if (ce) begin
      state_q <= state_d;
      s_q <= s_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      m0_q <= m0_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      d_o_q <= d_o_d;
    end
  end
endmodule

// File: tb/tb_mm_radix_pipe_param.sv
// tb_mm_radix_pipe_param: table, random and corner-case checks for 16/4 and 32/8 instances
module tb_mm_radix_pipe_param;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b0;
  logic init16 = 1'b0, init32 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, m16 = '0, d16 = '0, do16;
  logic [3:0] m0_16 = '0;
  logic [31:0] a32 = '0, b32 = '0, m32 = '0, d32 = '0, do32;
  logic [7:0] m0_32 = '0;
  logic busy16, done16, busy32, done32;
  int checks = 0, errors = 0;
  int lat, bc, cnt;
  logic [63:0] ra, rb, rd, rm, rm0;
  logic [15:0] r16;
  logic [31:0] r32;
  typedef struct {
    logic [15:0] a, b, d, m;
    logic [3:0] m0;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  mm_radix_pipe_param #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .ce(ce), .init(init16), .A(a16), .B(b16), .M(m16),
    .M0(m0_16), .D(d16), .D_o(do16), .busy(busy16), .done(done16));

  mm_radix_pipe_param #(.WIDTH(32), .DIGIT(8)) u32 (
    .clk(clk), .rst(rst), .ce(ce), .init(init32), .A(a32), .B(b32), .M(m32),
    .M0(m0_32), .D(d32), .D_o(do32), .busy(busy32), .done(done32));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mont(input logic [63:0] a, b, d, m, input int w);
    logic [63:0] x;
    x = (a * b + d) % m;
    for (int i = 0; i < w; i++) x = x[0] ? (x + m) >> 1 : x >> 1;
    return x;
  endfunction

  function automatic logic [63:0] m0of(input logic [63:0] m, input int dg);
    logic [63:0] md;
    md = 64'd1 << dg;
    for (int v = 0; v < (1 << dg); v++)
      if ((m * 64'(v) + 64'd1) % md == 64'd0) return 64'(v);
    return 64'd0;
  endfunction

  task automatic op16(input logic [15:0] a, b, d, m, input logic [3:0] m0,
                      output logic [15:0] r, output int l, output int bcount);
    @(negedge clk);
    a16 = a; b16 = b; d16 = d; m16 = m; m0_16 = m0; init16 = 1'b1;
    @(negedge clk);
    init16 = 1'b0;
    l = 0;
    bcount = 0;
    while (!done16 && l < 40) begin
      if (busy16) bcount++;
      @(negedge clk);
      l++;
    end
    r = do16;
  endtask

  task automatic op32(input logic [31:0] a, b, d, m, input logic [7:0] m0,
                      output logic [31:0] r, output int l);
    @(negedge clk);
    a32 = a; b32 = b; d32 = d; m32 = m; m0_32 = m0; init32 = 1'b1;
    @(negedge clk);
    init32 = 1'b0;
    l = 0;
    while (!done32 && l < 40) begin
      @(negedge clk);
      l++;
    end
    r = do32;
  endtask

  task automatic rnd16();
    rm = 64'($urandom_range(65535, 3) | 1);
    ra = 64'($urandom) % rm;
    rb = 64'($urandom) % rm;
    rd = 64'($urandom) % rm;
    rm0 = m0of(rm, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'd5, 16'd5, 16'd7, 16'd9, 4'd7, 16'd2};
    tbl[1] = '{16'd1, 16'd1, 16'd0, 16'd9, 4'd7, 16'd4};
    tbl[2] = '{16'd8, 16'd8, 16'd8, 16'd9, 4'd7, 16'd0};
    tbl[3] = '{16'd0, 16'd0, 16'd0, 16'd9, 4'd7, 16'd0};
    tbl[4] = '{16'd2, 16'd4, 16'd0, 16'd9, 4'd7, 16'd5};
    ce = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_do16", 64'(do16), 0);
    chk("rst_busy16", 64'(busy16), 0);
    chk("rst_done16", 64'(done16), 0);
    chk("rst_do32", 64'(do32), 0);
    chk("rst_busy32", 64'(busy32), 0);
    chk("rst_done32", 64'(done32), 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op16(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].m, tbl[i].m0, r16, lat, bc);
      chk("tbl_do", 64'(r16), 64'(tbl[i].exp));
      chk("tbl_lat", 64'(lat), 5);
      chk("tbl_busy_cycles", 64'(bc), 5);
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(done16), 0);
    chk("do_hold", 64'(do16), 5);
    op32(32'd1, 32'd1, 32'd0, 32'd9, 8'd199, r32, lat);
    chk("w32_do", 64'(r32), 7);
    chk("w32_lat", 64'(lat), 5);
    for (int i = 0; i < 200; i++) begin
      rm = 64'($urandom | 32'd1);
      if (rm < 64'd3) rm = 64'd3;
      ra = 64'($urandom) % rm;
      rb = 64'($urandom) % rm;
      rd = 64'($urandom) % rm;
      rm0 = m0of(rm, 8);
      op32(32'(ra), 32'(rb), 32'(rd), 32'(rm), 8'(rm0), r32, lat);
      chk("w32_rand_do", 64'(r32), mont(ra, rb, rd, rm, 32));
      if (lat != 5) chk("w32_rand_lat", 64'(lat), 5);
    end
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      rnd16();
      a16 = 16'(ra); b16 = 16'(rb); d16 = 16'(rd); m16 = 16'(rm); m0_16 = 4'(rm0);
      init16 = 1'b1;
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); d16 = 16'($urandom);
      cnt = 0;
      while (!done16 && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("b2b_spacing", 64'(cnt), 5);
      chk("b2b_do", 64'(do16), mont(ra, rb, rd, rm, 16));
    end
    init16 = 1'b0;
    @(negedge clk);
    chk("b2b_done_drop", 64'(done16), 0);
    a16 = 16'd5; b16 = 16'd5; d16 = 16'd7; m16 = 16'd9; m0_16 = 4'd7; init16 = 1'b1;
    @(negedge clk);
    init16 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      init16 = (i == 1 || i == 3);
      if (i == 1) begin a16 = 16'd8; b16 = 16'd8; end
      @(negedge clk);
      if (done16) cnt++;
    end
    init16 = 1'b0;
    chk("busy_init_ignored_dones", 64'(cnt), 1);
    chk("busy_init_ignored_do", 64'(do16), 2);
    a16 = 16'd5; b16 = 16'd5; d16 = 16'd7; m16 = 16'd9; m0_16 = 4'd7; init16 = 1'b1;
    @(negedge clk);
    init16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      ce = !(lat >= 2 && lat < 5);
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
    chk("ce_gap_lat", 64'(lat), 8);
    chk("ce_gap_do", 64'(do16), 2);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ce_done_frozen", 64'(done16), 1);
    end
    ce = 1'b1;
    @(negedge clk);
    chk("ce_done_release", 64'(done16), 0);
    op16(16'd1, 16'd1, 16'd0, 16'd9, 4'd7, r16, lat, bc);
    chk("pre_rst_do", 64'(r16), 4);
    a16 = 16'd8; b16 = 16'd8; d16 = 16'd8; init16 = 1'b1;
    @(negedge clk);
    init16 = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy16), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy16), 0);
    chk("async_rst_done", 64'(done16), 0);
    chk("async_rst_do", 64'(do16), 0);
    @(negedge clk);
    rst = 1'b1;
    op16(16'd5, 16'd5, 16'd7, 16'd9, 4'd7, r16, lat, bc);
    chk("post_rst_do", 64'(r16), 2);
    chk("post_rst_lat", 64'(lat), 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
